// File: rtl/cci_test_flow_pkg.sv
// ----------------------------------------------------------------------------
// cci_test_flow_pkg
//
// Shared types and helpers for the CCI test flow limiter.
//   t_active_cnt   - active-line counter at the default 512-line depth
//   t_cl_len       - 2-bit CCI line-length / packed-count code
//   t_line_delta   - per-cycle increment/decrement amount (0..4 lines)
//   t_flow_state   - per-channel throttle FSM state
//   cl_len_lines   - lines in a c0 read request for a cl_len code
//   wr_rsp_lines   - lines retired by one c1 write response
// ----------------------------------------------------------------------------
package cci_test_flow_pkg;

   localparam int MAX_ACTIVE_LINES_DEF = 512;
   localparam int CNT_BITS_DEF         = $clog2(MAX_ACTIVE_LINES_DEF) + 1;
   localparam int DELTA_BITS           = 3;

   typedef logic [CNT_BITS_DEF-1:0] t_active_cnt;
   typedef logic [1:0]              t_cl_len;
   typedef logic [DELTA_BITS-1:0]   t_line_delta;

   typedef enum logic [0:0] {
      OPEN      = 1'b0,
      THROTTLED = 1'b1
   } t_flow_state;

   // Code 2 is not a legal CCI length; it is counted as 3 lines.
   function automatic t_line_delta cl_len_lines(input t_cl_len cl_len);
      t_line_delta lines;
      case (cl_len)
         2'd0:    lines = 3'd1;
         2'd1:    lines = 3'd2;
         2'd2:    lines = 3'd3;
         default: lines = 3'd4;
      endcase
      return lines;
   endfunction

   // A packed write response retires cl_num+1 lines; unpacked retires one.
   function automatic t_line_delta wr_rsp_lines(input logic    packed_fmt,
                                                input t_cl_len cl_num);
      return packed_fmt ? (3'(cl_num) + 3'd1) : 3'd1;
   endfunction

endpackage

// File: rtl/cci_test_flow_chan.sv
// ----------------------------------------------------------------------------
// cci_test_flow_chan
//
// One channel of the flow limiter: active-line counter with saturation and
// underflow clamp, OPEN/THROTTLED hysteresis FSM, high watermark and sticky
// error bits.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   inc_i            lines added this cycle
//   dec_i            lines retired this cycle
//   limit_i          programmed line limit (0 = unlimited)
//   clear_i          clear watermark/errors (watermark reloads next count)
//   force_o          registered throttle request (state == THROTTLED)
//   state_o          FSM state, exposed for observation
//   count_o          current active lines
//   hwm_o            max active lines since last clear
//   err_under_o      sticky: a decrement exceeded the available count
//   err_over_o       sticky: the count saturated at MAX_ACTIVE_LINES
// ----------------------------------------------------------------------------
module cci_test_flow_chan
   import cci_test_flow_pkg::*;
#(
   parameter int  MAX_ACTIVE_LINES = 512,
   parameter int  ALM_FULL_SLACK   = 8,
   parameter int  HYST_LINES       = 4,
   localparam int CNT_BITS         = $clog2(MAX_ACTIVE_LINES) + 1
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  t_line_delta         inc_i,
   input  t_line_delta         dec_i,
   input  logic [CNT_BITS-1:0] limit_i,
   input  logic                clear_i,
   output logic                force_o,
   output t_flow_state         state_o,
   output logic [CNT_BITS-1:0] count_o,
   output logic [CNT_BITS-1:0] hwm_o,
   output logic                err_under_o,
   output logic                err_over_o
);

   // One extra bit so count+inc and limit-slack never wrap.
   localparam int WW = CNT_BITS + 1;

   logic [CNT_BITS-1:0] count_q, count_d;
   logic [CNT_BITS-1:0] hwm_q, hwm_d;
   logic                err_under_q, err_under_d;
   logic                err_over_q, err_over_d;
   t_flow_state         state_q, state_d;

   logic [WW-1:0] sum_w, net_w, next_w, limit_w, thr_w, rel_w;
   logic          under_set, over_set;

   // Net counter update: clamp to 0 on underflow, saturate on overflow.
   always_comb begin
      sum_w     = {1'b0, count_q} + WW'(inc_i);
      under_set = (WW'(dec_i) > sum_w);
      net_w     = under_set ? '0 : (sum_w - WW'(dec_i));
      over_set  = (net_w > WW'(MAX_ACTIVE_LINES));
      count_d   = over_set ? CNT_BITS'(MAX_ACTIVE_LINES) : net_w[CNT_BITS-1:0];
      next_w    = {1'b0, count_d};
   end

   // Throttle starts ALM_FULL_SLACK lines before the limit; release needs a
   // further HYST_LINES of drain. Both thresholds floor at zero.
   always_comb begin
      limit_w = {1'b0, limit_i};
      thr_w   = (limit_w > WW'(ALM_FULL_SLACK)) ? (limit_w - WW'(ALM_FULL_SLACK)) : '0;
      rel_w   = (thr_w > WW'(HYST_LINES)) ? (thr_w - WW'(HYST_LINES)) : '0;
   end

   // The FSM evaluates the next count so the throttle is visible in the same
   // cycle as the count that caused it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         OPEN: begin
            if ((limit_i != '0) && (next_w >= thr_w)) state_d = THROTTLED;
         end
         THROTTLED: begin
            if ((limit_i == '0) || (next_w <= rel_w)) state_d = OPEN;
         end
         default: state_d = OPEN;
      endcase
   end

   // Clear wins over a same-cycle error and reloads the watermark with the
   // next count rather than zero.
   always_comb begin
      if (clear_i) begin
         hwm_d       = count_d;
         err_under_d = 1'b0;
         err_over_d  = 1'b0;
      end else begin
         hwm_d       = (count_d > hwm_q) ? count_d : hwm_q;
         err_under_d = err_under_q | under_set;
         err_over_d  = err_over_q | over_set;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q     <= '0;
         hwm_q       <= '0;
         err_under_q <= 1'b0;
         err_over_q  <= 1'b0;
         state_q     <= OPEN;
      end else begin
         count_q     <= count_d;
         hwm_q       <= hwm_d;
         err_under_q <= err_under_d;
         err_over_q  <= err_over_d;
         state_q     <= state_d;
      end
   end

   assign force_o     = (state_q == THROTTLED);
   assign state_o     = state_q;
   assign count_o     = count_q;
   assign hwm_o       = hwm_q;
   assign err_under_o = err_under_q;
   assign err_over_o  = err_over_q;

endmodule

// File: rtl/cci_test_flow_limiter.sv
// ----------------------------------------------------------------------------
// cci_test_flow_limiter
//
// Watches FIU-side c0 read and c1 write traffic, counts active lines per
// channel and raises c0ForceAlmFull/c1ForceAlmFull (OR-ed into the FIU
// almost-full wires) when a count approaches its CSR-programmed limit.
// Also reports high watermarks and sticky accounting errors.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   c0_req_valid, c0_req_cl_len   accepted read request and its length code
//   c0_rsp_valid                  one read-response line
//   c1_req_valid                  one write data beat (no WrFence)
//   c1_rsp_valid, c1_rsp_format,
//   c1_rsp_cl_num                 write response, packed flag, lines-1
//   cfg_c0/c1_max_lines           per-channel limit, 0 = unlimited
//   cfg_clear_stats               pulse: clear watermarks and errors
//   c0/c1ForceAlmFull             throttle outputs
//   c0/c1ActiveLines              current counts
//   c0/c1_hwm                     watermarks since clear
//   err_underflow, err_overflow   sticky errors, [1]=c1, [0]=c0
// ----------------------------------------------------------------------------
module cci_test_flow_limiter
   import cci_test_flow_pkg::*;
#(
   parameter int  MAX_ACTIVE_LINES = 512,
   parameter int  ALM_FULL_SLACK   = 8,
   parameter int  HYST_LINES       = 4,
   localparam int CNT_BITS         = $clog2(MAX_ACTIVE_LINES) + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                c0_req_valid,
   input  logic [1:0]          c0_req_cl_len,
   input  logic                c0_rsp_valid,
   input  logic                c1_req_valid,
   input  logic                c1_rsp_valid,
   input  logic                c1_rsp_format,
   input  logic [1:0]          c1_rsp_cl_num,
   input  logic [CNT_BITS-1:0] cfg_c0_max_lines,
   input  logic [CNT_BITS-1:0] cfg_c1_max_lines,
   input  logic                cfg_clear_stats,
   output logic                c0ForceAlmFull,
   output logic                c1ForceAlmFull,
   output logic [CNT_BITS-1:0] c0ActiveLines,
   output logic [CNT_BITS-1:0] c1ActiveLines,
   output logic [CNT_BITS-1:0] c0_hwm,
   output logic [CNT_BITS-1:0] c1_hwm,
   output logic [1:0]          err_underflow,
   output logic [1:0]          err_overflow
);

   t_line_delta c0_inc, c0_dec, c1_inc, c1_dec;
   t_flow_state c0_state, c1_state;

   always_comb begin
      c0_inc = c0_req_valid ? cl_len_lines(c0_req_cl_len) : '0;
      c0_dec = c0_rsp_valid ? 3'd1 : '0;
      c1_inc = c1_req_valid ? 3'd1 : '0;
      c1_dec = c1_rsp_valid ? wr_rsp_lines(c1_rsp_format, c1_rsp_cl_num) : '0;
   end

   cci_test_flow_chan #(
      .MAX_ACTIVE_LINES (MAX_ACTIVE_LINES),
      .ALM_FULL_SLACK   (ALM_FULL_SLACK),
      .HYST_LINES       (HYST_LINES)
   ) u_c0 (
      .clk_i       (clk),
      .reset_i     (reset),
      .inc_i       (c0_inc),
      .dec_i       (c0_dec),
      .limit_i     (cfg_c0_max_lines),
      .clear_i     (cfg_clear_stats),
      .force_o     (c0ForceAlmFull),
      .state_o     (c0_state),
      .count_o     (c0ActiveLines),
      .hwm_o       (c0_hwm),
      .err_under_o (err_underflow[0]),
      .err_over_o  (err_overflow[0])
   );

   cci_test_flow_chan #(
      .MAX_ACTIVE_LINES (MAX_ACTIVE_LINES),
      .ALM_FULL_SLACK   (ALM_FULL_SLACK),
      .HYST_LINES       (HYST_LINES)
   ) u_c1 (
      .clk_i       (clk),
      .reset_i     (reset),
      .inc_i       (c1_inc),
      .dec_i       (c1_dec),
      .limit_i     (cfg_c1_max_lines),
      .clear_i     (cfg_clear_stats),
      .force_o     (c1ForceAlmFull),
      .state_o     (c1_state),
      .count_o     (c1ActiveLines),
      .hwm_o       (c1_hwm),
      .err_under_o (err_underflow[1]),
      .err_over_o  (err_overflow[1])
   );

endmodule

// File: tb/tb_cci_test_flow_limiter.sv
// ----------------------------------------------------------------------------
// tb_cci_test_flow_limiter
//
// Drives directed and random CCI traffic into cci_test_flow_limiter. An
// integer reference model predicts every output per cycle; predictions are
// queued at the clock edge and compared by a separate monitor on the falling
// edge. A few directed points are also checked against fixed values.
// ----------------------------------------------------------------------------
module tb_cci_test_flow_limiter;

   localparam int MAXL  = 512;
   localparam int SLACK = 8;
   localparam int HYST  = 4;
   localparam int CB    = 10;
   localparam int EW    = 4*CB + 6;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset;
   logic          c0_req_valid, c0_rsp_valid, c1_req_valid, c1_rsp_valid;
   logic [1:0]    c0_req_cl_len, c1_rsp_cl_num;
   logic          c1_rsp_format, cfg_clear_stats;
   logic [CB-1:0] cfg_c0_max_lines, cfg_c1_max_lines;
   logic          c0ForceAlmFull, c1ForceAlmFull;
   logic [CB-1:0] c0ActiveLines, c1ActiveLines, c0_hwm, c1_hwm;
   logic [1:0]    err_underflow, err_overflow;

   always #5 clk = ~clk;

   cci_test_flow_limiter dut (
      .clk              (clk),
      .reset            (reset),
      .c0_req_valid     (c0_req_valid),
      .c0_req_cl_len    (c0_req_cl_len),
      .c0_rsp_valid     (c0_rsp_valid),
      .c1_req_valid     (c1_req_valid),
      .c1_rsp_valid     (c1_rsp_valid),
      .c1_rsp_format    (c1_rsp_format),
      .c1_rsp_cl_num    (c1_rsp_cl_num),
      .cfg_c0_max_lines (cfg_c0_max_lines),
      .cfg_c1_max_lines (cfg_c1_max_lines),
      .cfg_clear_stats  (cfg_clear_stats),
      .c0ForceAlmFull   (c0ForceAlmFull),
      .c1ForceAlmFull   (c1ForceAlmFull),
      .c0ActiveLines    (c0ActiveLines),
      .c1ActiveLines    (c1ActiveLines),
      .c0_hwm           (c0_hwm),
      .c1_hwm           (c1_hwm),
      .err_underflow    (err_underflow),
      .err_overflow     (err_overflow)
   );

   // ---------------- scoreboard ----------------
   int tests_run    = 0;
   int tests_failed = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Active lines held as plain integers; throttle follows the threshold /
   // release rules with hysteresis.
   int m_cnt[2];
   int m_hwm[2];
   bit m_thr[2];
   bit [1:0] m_under, m_over;

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_cnt[c] = 0;
         m_hwm[c] = 0;
         m_thr[c] = 1'b0;
      end
      m_under = '0;
      m_over  = '0;
   endtask

   task automatic model_chan(input int ch, input int inc, input int dec, input int lim, input bit clr);
      int t, thr, rel;
      bit us, os;
      us = 1'b0;
      os = 1'b0;
      t  = m_cnt[ch] + inc - dec;
      if (t < 0) begin t = 0; us = 1'b1; end
      if (t > MAXL) begin t = MAXL; os = 1'b1; end
      thr = lim - SLACK;
      if (thr < 0) thr = 0;
      rel = thr - HYST;
      if (rel < 0) rel = 0;
      if (!m_thr[ch]) m_thr[ch] = (lim != 0) && (t >= thr);
      else            m_thr[ch] = !((lim == 0) || (t <= rel));
      m_cnt[ch] = t;
      if (clr) begin
         m_hwm[ch]   = t;
         m_under[ch] = 1'b0;
         m_over[ch]  = 1'b0;
      end else begin
         if (t > m_hwm[ch]) m_hwm[ch] = t;
         if (us) m_under[ch] = 1'b1;
         if (os) m_over[ch]  = 1'b1;
      end
   endtask

   function automatic logic [EW-1:0] model_pack();
      return {CB'(m_cnt[0]), CB'(m_cnt[1]), CB'(m_hwm[0]), CB'(m_hwm[1]),
              m_thr[1], m_thr[0], m_under, m_over};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      logic [EW-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("c0ActiveLines",  32'(c0ActiveLines),  32'(e[45:36]));
         check("c1ActiveLines",  32'(c1ActiveLines),  32'(e[35:26]));
         check("c0_hwm",         32'(c0_hwm),         32'(e[25:16]));
         check("c1_hwm",         32'(c1_hwm),         32'(e[15:6]));
         check("c1ForceAlmFull", 32'(c1ForceAlmFull), 32'(e[5]));
         check("c0ForceAlmFull", 32'(c0ForceAlmFull), 32'(e[4]));
         check("err_underflow",  32'(err_underflow),  32'(e[3:2]));
         check("err_overflow",   32'(err_overflow),   32'(e[1:0]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input bit rq0, input bit [1:0] len, input bit rs0,
                       input bit rq1, input bit rs1, input bit fmt,
                       input bit [1:0] cln, input bit clr);
      int inc0, dec1;
      reset           = 1'b0;
      c0_req_valid    = rq0;
      c0_req_cl_len   = len;
      c0_rsp_valid    = rs0;
      c1_req_valid    = rq1;
      c1_rsp_valid    = rs1;
      c1_rsp_format   = fmt;
      c1_rsp_cl_num   = cln;
      cfg_clear_stats = clr;
      inc0 = 0;
      if (rq0) inc0 = (len == 2'd2) ? 3 : int'(len) + 1;
      dec1 = 0;
      if (rs1) dec1 = fmt ? int'(cln) + 1 : 1;
      model_chan(0, inc0, int'(rs0), int'(cfg_c0_max_lines), clr);
      model_chan(1, int'(rq1), dec1, int'(cfg_c1_max_lines), clr);
      @(posedge clk);
      exp_q.push_back(model_pack());
      #1;
   endtask

   task automatic idle();
      step(0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
   endtask

   task automatic read(input bit [1:0] len);
      step(1, len, 0, 0, 0, 0, 2'd0, 0);
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      c0_req_valid    = 1'b0;
      c0_req_cl_len   = 2'd0;
      c0_rsp_valid    = 1'b0;
      c1_req_valid    = 1'b0;
      c1_rsp_valid    = 1'b0;
      c1_rsp_format   = 1'b0;
      c1_rsp_cl_num   = 2'd0;
      cfg_clear_stats = 1'b0;
      model_reset();
      @(posedge clk);
      exp_q.push_back(model_pack());
      #1;
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      cfg_c0_max_lines = '0;
      cfg_c1_max_lines = '0;
      do_reset();
      check("reset_c0ForceAlmFull", 32'(c0ForceAlmFull), 32'd0);
      check("reset_err_underflow",  32'(err_underflow),  32'd0);

      // Unlimited c0: 100 single-line reads, no responses.
      for (int i = 0; i < 100; i++) read(2'd0);
      check("unlim_c0_count", 32'(c0ActiveLines),  32'd100);
      check("unlim_c0_force", 32'(c0ForceAlmFull), 32'd0);
      check("unlim_c0_hwm",   32'(c0_hwm),         32'd100);

      // Limit 32 -> thr 24, rel 20.
      do_reset();
      cfg_c0_max_lines = 10'd32;
      for (int i = 0; i < 5; i++) read(2'd3);
      check("thr_c0_at20_force", 32'(c0ForceAlmFull), 32'd0);
      read(2'd3);
      check("thr_c0_at24_count", 32'(c0ActiveLines),  32'd24);
      check("thr_c0_at24_force", 32'(c0ForceAlmFull), 32'd1);
      for (int i = 0; i < 3; i++) step(0, 2'd0, 1, 0, 0, 0, 2'd0, 0);
      check("rel_c0_at21_force", 32'(c0ForceAlmFull), 32'd1);
      step(0, 2'd0, 1, 0, 0, 0, 2'd0, 0);
      check("rel_c0_at20_count", 32'(c0ActiveLines),  32'd20);
      check("rel_c0_at20_force", 32'(c0ForceAlmFull), 32'd0);

      // Limit dropped below the current count throttles on the next cycle.
      cfg_c0_max_lines = 10'd10;
      idle();
      check("limdrop_c0_force", 32'(c0ForceAlmFull), 32'd1);
      cfg_c0_max_lines = 10'd0;
      idle();
      check("limzero_c0_force", 32'(c0ForceAlmFull), 32'd0);

      // c1: 4 beats, then a beat together with a packed 4-line response.
      for (int i = 0; i < 4; i++) step(0, 2'd0, 0, 1, 0, 0, 2'd0, 0);
      check("c1_after4", 32'(c1ActiveLines), 32'd4);
      step(0, 2'd0, 0, 1, 1, 1, 2'd3, 0);
      check("c1_packed_net", 32'(c1ActiveLines),    32'd1);
      check("c1_packed_err", 32'(err_underflow[1]), 32'd0);

      // c0 underflow at zero, then clear together with a response.
      do_reset();
      step(0, 2'd0, 1, 0, 0, 0, 2'd0, 0);
      check("uf_c0_count", 32'(c0ActiveLines),    32'd0);
      check("uf_c0_err",   32'(err_underflow[0]), 32'd1);
      read(2'd3);
      read(2'd3);
      for (int i = 0; i < 5; i++) step(0, 2'd0, 1, 0, 0, 0, 2'd0, 0);
      step(0, 2'd0, 1, 0, 0, 0, 2'd0, 1);
      check("clr_err",    32'(err_underflow), 32'd0);
      check("clr_c0_hwm", 32'(c0_hwm),        32'd2);

      // Reset while throttled at 30, then a stale c1 response.
      do_reset();
      cfg_c0_max_lines = 10'd32;
      for (int i = 0; i < 7; i++) read(2'd3);
      read(2'd1);
      check("pre_rst_count", 32'(c0ActiveLines),  32'd30);
      check("pre_rst_force", 32'(c0ForceAlmFull), 32'd1);
      do_reset();
      check("rst_count", 32'(c0ActiveLines),  32'd0);
      check("rst_force", 32'(c0ForceAlmFull), 32'd0);
      check("rst_hwm",   32'(c0_hwm),         32'd0);
      step(0, 2'd0, 0, 0, 1, 0, 2'd0, 0);
      check("stale_c1_err", 32'(err_underflow), 32'd2);

      // c0 overflow: saturates at MAX_ACTIVE_LINES.
      do_reset();
      cfg_c0_max_lines = 10'd0;
      for (int i = 0; i < 130; i++) read(2'd3);
      check("ovf_c0_count", 32'(c0ActiveLines), 32'(MAXL));
      check("ovf_c0_err",   32'(err_overflow),  32'd1);

      // Random traffic with changing limits and occasional clears.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (i % 60 == 0) begin
            case ($urandom_range(2, 0))
               0:       cfg_c0_max_lines = '0;
               1:       cfg_c0_max_lines = CB'($urandom_range(20, 1));
               default: cfg_c0_max_lines = CB'($urandom_range(200, 20));
            endcase
            case ($urandom_range(2, 0))
               0:       cfg_c1_max_lines = '0;
               1:       cfg_c1_max_lines = CB'($urandom_range(20, 1));
               default: cfg_c1_max_lines = CB'($urandom_range(200, 20));
            endcase
         end
         step($urandom_range(99, 0) < 40, 2'($urandom_range(3, 0)),
              $urandom_range(99, 0) < 70,
              $urandom_range(99, 0) < 60, $urandom_range(99, 0) < 35,
              1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
              $urandom_range(99, 0) < 2);
      end

      idle();
      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cci_test_flow_limiter.md
Name: cci_test_flow_limiter

Overview:
- Sits beside the FIU-side CCI bus, between the FIU flow wrapper and the test AFU.
- Observes c0 read traffic and c1 write traffic and keeps a per-channel count of active lines.
- Compares each count against a CSR-programmed limit and drives c0ForceAlmFull/c1ForceAlmFull, which are OR-ed into the FIU almost-full wires.
- Also reports high-watermark statistics and sticky accounting errors to the test CSRs.

Parameters:
- MAX_ACTIVE_LINES, 512: largest count tracked per channel; counters are $clog2(MAX_ACTIVE_LINES)+1 bits.
- ALM_FULL_SLACK, 8: requests the AFU may still issue after almost-full asserts; throttling starts this many lines early.
- HYST_LINES, 4: additional drain below the threshold required before throttling releases.

Ports:
- clk  in  1  single AFU clock.
- reset  in  1  synchronous, active-high reset.
- c0_req_valid  in  1  c0 read request accepted by FIU.
- c0_req_cl_len  in  2  read length code (0=1, 1=2, 3=4 lines).
- c0_rsp_valid  in  1  one read-response line returned.
- c1_req_valid  in  1  c1 write data beat (one line), excluding WrFence.
- c1_rsp_valid  in  1  write response, excluding fence response.
- c1_rsp_format  in  1  packed write response.
- c1_rsp_cl_num  in  2  packed line count minus 1.
- cfg_c0_max_lines  in  CNT_BITS  c0 limit; 0 = unlimited.
- cfg_c1_max_lines  in  CNT_BITS  c1 limit; 0 = unlimited.
- cfg_clear_stats  in  1  one-cycle pulse clearing watermarks and errors.
- c0ForceAlmFull  out  1  throttle c0.
- c1ForceAlmFull  out  1  throttle c1.
- c0ActiveLines  out  CNT_BITS  current c0 count.
- c1ActiveLines  out  CNT_BITS  current c1 count.
- c0_hwm  out  CNT_BITS  c0 max count since clear.
- c1_hwm  out  CNT_BITS  c1 max count since clear.
- err_underflow  out  2  sticky, per channel [1:0]=c1,c0.
- err_overflow  out  2  sticky, per channel [1:0]=c1,c0.

Behaviour:
- Reset: every output is 0, counters are 0, and both FSMs are in OPEN.
- Line counting:
  - c0 increment = cl_len+1 for codes 0/1/3; code 2 is treated as 3 lines.
  - c0 decrement = 1 per c0_rsp_valid.
  - c1 increment = 1 per c1_req_valid.
  - c1 decrement = c1_rsp_format ? c1_rsp_cl_num+1 : 1.
- Simultaneous increment and decrement in one cycle apply the net value. Counts are registered and visible 1 cycle after the event.
- Underflow (decrement > count+increment):
  - Count clamps to 0 and err_underflow bit sets.
  - Errors clear only on reset or cfg_clear_stats.
- Overflow (result > MAX_ACTIVE_LINES): count saturates at MAX_ACTIVE_LINES and err_overflow bit sets.
- Threshold:
  - thr = limit - ALM_FULL_SLACK, computed with width CNT_BITS+1; a negative thr is treated as 0.
  - rel = thr - HYST_LINES, floored at 0.
- FSM per channel:
  - OPEN -> THROTTLED when limit != 0 and next count >= thr.
  - THROTTLED -> OPEN when limit == 0 or next count <= rel.
  - ForceAlmFull is registered: 1 exactly when the FSM is in THROTTLED. This gives 1-cycle latency from the causing event.
- A limit change takes effect on the next cycle's evaluation. Dropping a limit below the current count forces THROTTLED on the next cycle.
- Watermark: hwm <= max(hwm, next count) every cycle. cfg_clear_stats loads hwm with the current next count, not 0; it has priority over a same-cycle error set.
- Reset mid-operation discards in-flight accounting. Responses arriving after reset therefore set err_underflow by design.

Decomposition:
- Package cci_test_flow_pkg:
  - t_active_cnt and t_cl_len typedefs.
  - Line-count decode function for cl_len and packed responses.
  - FSM enum t_flow_state {OPEN, THROTTLED}.
- Sub-module cci_test_flow_chan, instantiated twice (c0, c1):
  - Contains counter, saturation and clamp logic, FSM, watermark and error bits.
  - Inputs are increment and decrement amounts plus the limit.

Test Plan:
- Reset, then cfg_c0_max_lines=0 and 100 single-line reads with no responses -> c0ActiveLines=100, c0ForceAlmFull stays 0, c0_hwm=100.
- cfg_c0_max_lines=32, then 6 reads of cl_len=3 (24 lines) -> c0ForceAlmFull rises the cycle after count reaches 24 (thr=24).
- From that state, return responses one per cycle -> c0ForceAlmFull stays high through count 21 and drops the cycle after count reaches 20.
- c1: 4 write beats, then one packed response with format=1, cl_num=3 in the same cycle as a 5th beat -> c1ActiveLines 4 -> 1, no error.
- Response on c0 with count=0 -> count stays 0, err_underflow[0]=1. After a cfg_clear_stats pulse -> err_underflow=0 and c0_hwm equals the current count.
- Count at 30 with throttle active, assert reset for 1 cycle -> all outputs 0 next cycle. A subsequent c1 response sets err_underflow[1].
